// File: rtl/simple_commit_fifo.sv
// simple_commit_fifo: synchronous FIFO with speculative writes that become readable only on
// commit and can be discarded with drop, plus almost-full / almost-empty watermarks.
// Optional macro SIMPLE_COMMIT_FIFO_OUT_REG_EN adds a one-entry registered output stage.
module simple_commit_fifo #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  din_valid_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic                  din_ready_o,
    input  logic                  din_commit_i,
    input  logic                  din_drop_i,
    output logic                  dout_valid_o,
    output logic [DATA_WIDTH-1:0] dout_o,
    input  logic                  dout_ready_i,
    input  logic [ADDR_WIDTH:0]   afull_thresh_i,
    input  logic [ADDR_WIDTH:0]   aempty_thresh_i,
    output logic [ADDR_WIDTH:0]   item_count_o,
    output logic [ADDR_WIDTH:0]   used_count_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  drop_pulse_o
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DepthCnt = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PtrOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0]   wptr_spec_q, wptr_spec_d;
    logic [ADDR_WIDTH:0]   wptr_cmt_q, wptr_cmt_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic                  drop_pulse_q, drop_pulse_d;
    logic [DATA_WIDTH-1:0] mem_q [Depth];

    logic                  full;
    logic                  enq;
    logic                  pop_mem;
    logic                  mem_avail;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [ADDR_WIDTH:0]   cmt_count;

    assign used_count_o = wptr_spec_q - rptr_q;
    assign cmt_count    = wptr_cmt_q - rptr_q;
    assign full         = (used_count_o == DepthCnt);
    assign din_ready_o  = ~full & ~din_drop_i & ~rst & ~clear_i;
    assign enq          = din_valid_i & din_ready_o;
    assign mem_avail    = (rptr_q != wptr_cmt_q);
    assign mem_rdata    = mem_q[rptr_q[ADDR_WIDTH-1:0]];
    assign drop_pulse_o = drop_pulse_q;

    assign almost_full_o  = (used_count_o >= afull_thresh_i);
    assign almost_empty_o = (item_count_o <= aempty_thresh_i);

`ifdef SIMPLE_COMMIT_FIFO_OUT_REG_EN
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q;

    // Refill the output register whenever it is empty or being drained this cycle.
    assign pop_mem      = mem_avail & (~out_valid_q | dout_ready_i);
    assign out_valid_d  = pop_mem | (out_valid_q & ~dout_ready_i);
    assign dout_valid_o = out_valid_q;
    assign dout_o       = out_data_q;
    assign item_count_o = cmt_count + {{ADDR_WIDTH{1'b0}}, out_valid_q};

    // Output stage register; flushed together with the pointers.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
        if (pop_mem) begin
            out_data_q <= mem_rdata;
        end
    end
`else
    assign dout_valid_o = mem_avail;
    assign dout_o       = mem_rdata;
    assign pop_mem      = mem_avail & dout_ready_i;
    assign item_count_o = cmt_count;
`endif

    // Next-state for pointers; drop overrides both enqueue and commit.
    always_comb begin
        wptr_spec_d  = wptr_spec_q;
        wptr_cmt_d   = wptr_cmt_q;
        rptr_d       = rptr_q + {{ADDR_WIDTH{1'b0}}, pop_mem};
        drop_pulse_d = din_drop_i & (wptr_spec_q != wptr_cmt_q);
        if (din_drop_i) begin
            wptr_spec_d = wptr_cmt_q;
        end else begin
            if (enq) begin
                wptr_spec_d = wptr_spec_q + PtrOne;
            end
            if (din_commit_i) begin
                // The word accepted this cycle belongs to the committed group.
                wptr_cmt_d = enq ? (wptr_spec_q + PtrOne) : wptr_spec_q;
            end
        end
    end

    // Pointer and pulse registers; clear behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wptr_spec_q  <= '0;
            wptr_cmt_q   <= '0;
            rptr_q       <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            wptr_spec_q  <= wptr_spec_d;
            wptr_cmt_q   <= wptr_cmt_d;
            rptr_q       <= rptr_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    // Storage array; enq is already suppressed during reset, clear and drop.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wptr_spec_q[ADDR_WIDTH-1:0]] <= din_i;
        end
    end

endmodule

// File: tb/tb_simple_commit_fifo.sv
// Directed bench for simple_commit_fifo (default build, 8-entry instance).
module tb_simple_commit_fifo;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 16;

    logic          clk;
    logic          rst;
    logic          clear_i;
    logic          din_valid_i;
    logic [DW-1:0] din_i;
    logic          din_ready_o;
    logic          din_commit_i;
    logic          din_drop_i;
    logic          dout_valid_o;
    logic [DW-1:0] dout_o;
    logic          dout_ready_i;
    logic [AW:0]   afull_thresh_i;
    logic [AW:0]   aempty_thresh_i;
    logic [AW:0]   item_count_o;
    logic [AW:0]   used_count_o;
    logic          almost_full_o;
    logic          almost_empty_o;
    logic          drop_pulse_o;

    int tests = 0;
    int fails = 0;

    simple_commit_fifo #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (clear_i),
        .din_valid_i    (din_valid_i),
        .din_i          (din_i),
        .din_ready_o    (din_ready_o),
        .din_commit_i   (din_commit_i),
        .din_drop_i     (din_drop_i),
        .dout_valid_o   (dout_valid_o),
        .dout_o         (dout_o),
        .dout_ready_i   (dout_ready_i),
        .afull_thresh_i (afull_thresh_i),
        .aempty_thresh_i(aempty_thresh_i),
        .item_count_o   (item_count_o),
        .used_count_o   (used_count_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .drop_pulse_o   (drop_pulse_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        din_valid_i  = 1'b0;
        din_commit_i = 1'b0;
        din_drop_i   = 1'b0;
        clear_i      = 1'b0;
        din_i        = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        dout_ready_i    = 1'b0;
        afull_thresh_i  = 4'd0;
        aempty_thresh_i = 4'd1;
        tick();
        tick();
        tests++; if (din_ready_o !== 1'b0) begin fails++; $display("FAIL reset_din_ready got=%b exp=0", din_ready_o); end
        tests++; if (dout_valid_o !== 1'b0) begin fails++; $display("FAIL reset_dout_valid got=%b exp=0", dout_valid_o); end
        tests++; if (item_count_o !== 4'd0) begin fails++; $display("FAIL reset_item got=%0d exp=0", item_count_o); end
        tests++; if (used_count_o !== 4'd0) begin fails++; $display("FAIL reset_used got=%0d exp=0", used_count_o); end
        tests++; if (almost_full_o !== 1'b1) begin fails++; $display("FAIL reset_afull_thr0 got=%b exp=1", almost_full_o); end
        tests++; if (almost_empty_o !== 1'b1) begin fails++; $display("FAIL reset_aempty got=%b exp=1", almost_empty_o); end
        tests++; if (drop_pulse_o !== 1'b0) begin fails++; $display("FAIL reset_drop_pulse got=%b exp=0", drop_pulse_o); end
        rst = 1'b0;
        afull_thresh_i = 4'd6;
        #1;
        tests++; if (din_ready_o !== 1'b1) begin fails++; $display("FAIL post_reset_din_ready got=%b exp=1", din_ready_o); end
        tests++; if (almost_full_o !== 1'b0) begin fails++; $display("FAIL post_reset_afull got=%b exp=0", almost_full_o); end
    endtask

    task automatic test_commit();
        logic [DW-1:0] exp;
        dout_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din_valid_i  = 1'b1;
            din_i        = 16'hA000 + 16'(i);
            din_commit_i = (i == 3);
            #1;
            tests++; if (dout_valid_o !== 1'b0) begin fails++; $display("FAIL commit_prevalid[%0d] got=%b exp=0", i, dout_valid_o); end
            tests++; if (used_count_o !== 4'(i)) begin fails++; $display("FAIL commit_used[%0d] got=%0d exp=%0d", i, used_count_o, i); end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            exp = 16'hA000 + 16'(i);
            #1;
            tests++; if (dout_valid_o !== 1'b1 || dout_o !== exp) begin fails++; $display("FAIL commit_read[%0d] got=%b/%h exp=1/%h", i, dout_valid_o, dout_o, exp); end
            tests++; if (item_count_o !== 4'(4 - i)) begin fails++; $display("FAIL commit_item[%0d] got=%0d exp=%0d", i, item_count_o, 4 - i); end
            tick();
        end
        tests++; if (dout_valid_o !== 1'b0 || item_count_o !== 4'd0) begin fails++; $display("FAIL commit_drained got=%b/%0d exp=0/0", dout_valid_o, item_count_o); end
    endtask

    task automatic test_drop();
        dout_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din_valid_i = 1'b1;
            din_i       = 16'hBAD0 + 16'(i);
            tick();
        end
        din_drop_i  = 1'b1;
        din_valid_i = 1'b1;
        din_i       = 16'hDEAD;
        #1;
        tests++; if (din_ready_o !== 1'b0) begin fails++; $display("FAIL drop_ready got=%b exp=0", din_ready_o); end
        tests++; if (used_count_o !== 4'd3) begin fails++; $display("FAIL drop_used_before got=%0d exp=3", used_count_o); end
        tick();
        idle_inputs();
        #1;
        tests++; if (used_count_o !== 4'd0) begin fails++; $display("FAIL drop_used_after got=%0d exp=0", used_count_o); end
        tests++; if (drop_pulse_o !== 1'b1) begin fails++; $display("FAIL drop_pulse got=%b exp=1", drop_pulse_o); end
        tests++; if (dout_valid_o !== 1'b0) begin fails++; $display("FAIL drop_dout_valid got=%b exp=0", dout_valid_o); end
        tests++; if (din_ready_o !== 1'b1) begin fails++; $display("FAIL drop_ready_after got=%b exp=1", din_ready_o); end
        tick();
        tests++; if (drop_pulse_o !== 1'b0) begin fails++; $display("FAIL drop_pulse_width got=%b exp=0", drop_pulse_o); end
        // Drop with nothing pending must not pulse.
        din_drop_i = 1'b1;
        tick();
        din_drop_i = 1'b0;
        #1;
        tests++; if (drop_pulse_o !== 1'b0) begin fails++; $display("FAIL drop_empty_pulse got=%b exp=0", drop_pulse_o); end
        // Next group reuses the dropped slots.
        din_valid_i = 1'b1; din_i = 16'hB100; din_commit_i = 1'b0;
        tick();
        din_i = 16'hB101; din_commit_i = 1'b1;
        tick();
        idle_inputs();
        #1;
        tests++; if (dout_valid_o !== 1'b1 || dout_o !== 16'hB100) begin fails++; $display("FAIL drop_reuse0 got=%b/%h exp=1/b100", dout_valid_o, dout_o); end
        tick();
        tests++; if (dout_valid_o !== 1'b1 || dout_o !== 16'hB101) begin fails++; $display("FAIL drop_reuse1 got=%b/%h exp=1/b101", dout_valid_o, dout_o); end
        tick();
        tests++; if (dout_valid_o !== 1'b0) begin fails++; $display("FAIL drop_reuse_empty got=%b exp=0", dout_valid_o); end
    endtask

    task automatic test_full();
        logic [DW-1:0] exp;
        dout_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            din_valid_i  = 1'b1;
            din_i        = 16'hC000 + 16'(i);
            din_commit_i = (i == 7);
            #1;
            tests++; if (din_ready_o !== 1'b1) begin fails++; $display("FAIL full_fill_ready[%0d] got=%b exp=1", i, din_ready_o); end
            tick();
        end
        din_commit_i = 1'b0;
        din_i        = 16'hFFFF;
        #1;
        tests++; if (din_ready_o !== 1'b0) begin fails++; $display("FAIL full_ready got=%b exp=0", din_ready_o); end
        tests++; if (used_count_o !== 4'd8 || item_count_o !== 4'd8) begin fails++; $display("FAIL full_counts got=%0d/%0d exp=8/8", used_count_o, item_count_o); end
        tests++; if (almost_full_o !== 1'b1) begin fails++; $display("FAIL full_afull got=%b exp=1", almost_full_o); end
        tick();
        tests++; if (used_count_o !== 4'd8) begin fails++; $display("FAIL full_no_enq got=%0d exp=8", used_count_o); end
        din_valid_i  = 1'b0;
        dout_ready_i = 1'b1;
        #1;
        tests++; if (dout_o !== 16'hC000) begin fails++; $display("FAIL full_first got=%h exp=c000", dout_o); end
        tick();
        dout_ready_i = 1'b0;
        #1;
        tests++; if (din_ready_o !== 1'b1 || used_count_o !== 4'd7) begin fails++; $display("FAIL full_after_read got=%b/%0d exp=1/7", din_ready_o, used_count_o); end
        dout_ready_i = 1'b1;
        for (int i = 1; i < 8; i++) begin
            exp = 16'hC000 + 16'(i);
            #1;
            tests++; if (dout_valid_o !== 1'b1 || dout_o !== exp) begin fails++; $display("FAIL full_drain[%0d] got=%b/%h exp=1/%h", i, dout_valid_o, dout_o, exp); end
            tick();
        end
        tests++; if (dout_valid_o !== 1'b0) begin fails++; $display("FAIL full_drained got=%b exp=0", dout_valid_o); end
    endtask

    task automatic test_commit_drop();
        dout_ready_i = 1'b0;
        din_valid_i = 1'b1; din_i = 16'hE000; din_commit_i = 1'b1;
        tick();
        din_commit_i = 1'b0;
        din_i = 16'hE001;
        tick();
        din_i = 16'hE002;
        tick();
        din_commit_i = 1'b1;
        din_drop_i   = 1'b1;
        din_i        = 16'hE0FF;
        #1;
        tests++; if (din_ready_o !== 1'b0) begin fails++; $display("FAIL cd_ready got=%b exp=0", din_ready_o); end
        tests++; if (used_count_o !== 4'd3 || item_count_o !== 4'd1) begin fails++; $display("FAIL cd_before got=%0d/%0d exp=3/1", used_count_o, item_count_o); end
        tick();
        idle_inputs();
        #1;
        tests++; if (item_count_o !== 4'd1) begin fails++; $display("FAIL cd_item got=%0d exp=1", item_count_o); end
        tests++; if (used_count_o !== 4'd1) begin fails++; $display("FAIL cd_used got=%0d exp=1", used_count_o); end
        tests++; if (drop_pulse_o !== 1'b1) begin fails++; $display("FAIL cd_pulse got=%b exp=1", drop_pulse_o); end
        dout_ready_i = 1'b1;
        #1;
        tests++; if (dout_valid_o !== 1'b1 || dout_o !== 16'hE000) begin fails++; $display("FAIL cd_read got=%b/%h exp=1/e000", dout_valid_o, dout_o); end
        tick();
        tests++; if (dout_valid_o !== 1'b0) begin fails++; $display("FAIL cd_empty got=%b exp=0", dout_valid_o); end
    endtask

    task automatic test_clear();
        dout_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din_valid_i  = 1'b1;
            din_i        = 16'hF000 + 16'(i);
            din_commit_i = (i == 1);
            tick();
        end
        din_commit_i = 1'b0;
        #1;
        tests++; if (used_count_o !== 4'd5 || item_count_o !== 4'd2) begin fails++; $display("FAIL clr_before got=%0d/%0d exp=5/2", used_count_o, item_count_o); end
        clear_i = 1'b1;
        #1;
        tests++; if (din_ready_o !== 1'b0) begin fails++; $display("FAIL clr_ready got=%b exp=0", din_ready_o); end
        tick();
        idle_inputs();
        #1;
        tests++; if (used_count_o !== 4'd0 || item_count_o !== 4'd0 || dout_valid_o !== 1'b0) begin fails++; $display("FAIL clr_after got=%0d/%0d/%b exp=0/0/0", used_count_o, item_count_o, dout_valid_o); end
        din_valid_i = 1'b1; din_i = 16'h6000;
        tick();
        din_i = 16'h6001; din_commit_i = 1'b1;
        tick();
        idle_inputs();
        dout_ready_i = 1'b1;
        #1;
        tests++; if (dout_valid_o !== 1'b1 || dout_o !== 16'h6000) begin fails++; $display("FAIL clr_read0 got=%b/%h exp=1/6000", dout_valid_o, dout_o); end
        tick();
        tests++; if (dout_valid_o !== 1'b1 || dout_o !== 16'h6001) begin fails++; $display("FAIL clr_read1 got=%b/%h exp=1/6001", dout_valid_o, dout_o); end
        tick();
        tests++; if (dout_valid_o !== 1'b0) begin fails++; $display("FAIL clr_empty got=%b exp=0", dout_valid_o); end
    endtask

    task automatic test_watermark();
        logic [DW-1:0] exp;
        afull_thresh_i  = 4'd6;
        aempty_thresh_i = 4'd1;
        for (int r = 0; r < 3; r++) begin
            dout_ready_i = 1'b0;
            for (int k = 0; k <= 8; k++) begin
                din_valid_i  = (k < 8);
                din_commit_i = (k < 8);
                din_i        = 16'h7000 + 16'(r * 16 + k);
                #1;
                tests++; if (used_count_o !== 4'(k) || item_count_o !== 4'(k)) begin fails++; $display("FAIL wm_up_cnt[%0d.%0d] got=%0d/%0d exp=%0d", r, k, used_count_o, item_count_o, k); end
                tests++; if (almost_full_o !== (k >= 6)) begin fails++; $display("FAIL wm_up_afull[%0d.%0d] got=%b exp=%b", r, k, almost_full_o, k >= 6); end
                tests++; if (almost_empty_o !== (k <= 1)) begin fails++; $display("FAIL wm_up_aempty[%0d.%0d] got=%b exp=%b", r, k, almost_empty_o, k <= 1); end
                tick();
            end
            idle_inputs();
            dout_ready_i = 1'b1;
            for (int k = 8; k >= 0; k--) begin
                exp = 16'h7000 + 16'(r * 16 + 8 - k);
                #1;
                tests++; if (item_count_o !== 4'(k)) begin fails++; $display("FAIL wm_dn_cnt[%0d.%0d] got=%0d exp=%0d", r, k, item_count_o, k); end
                tests++; if (almost_full_o !== (k >= 6)) begin fails++; $display("FAIL wm_dn_afull[%0d.%0d] got=%b exp=%b", r, k, almost_full_o, k >= 6); end
                tests++; if (almost_empty_o !== (k <= 1)) begin fails++; $display("FAIL wm_dn_aempty[%0d.%0d] got=%b exp=%b", r, k, almost_empty_o, k <= 1); end
                if (k > 0) begin
                    tests++; if (dout_valid_o !== 1'b1 || dout_o !== exp) begin fails++; $display("FAIL wm_dn_data[%0d.%0d] got=%b/%h exp=1/%h", r, k, dout_valid_o, dout_o, exp); end
                end
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_drop();
        test_full();
        test_commit_drop();
        test_clear();
        test_watermark();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/simple_commit_fifo.md
# simple_commit_fifo

Synchronous FIFO that extends the team's `simple_fifo` with commit/drop semantics and programmable watermarks. Writers push words speculatively and then either commit the group, making it readable, or drop it, reclaiming the space. Used between packet parsers and cores wherever a partially received message must be discarded without ever reaching the consumer. Optionally adds a registered output stage for timing closure.

## Interface
- `ADDR_WIDTH`, 5: log2 of depth; depth D = 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 32: word width.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `clear` input 1: synchronous flush; same effect as `rst` on all state.
- `din_valid` input 1: write request.
- `din` input DATA_WIDTH: write data.
- `din_ready` output 1: write accepted when `din_valid & din_ready`.
- `din_commit` input 1: commit all words written since the last commit/drop, including the current accepted word.
- `din_drop` input 1: discard all uncommitted words.
- `dout_valid` output 1: committed word available.
- `dout` output DATA_WIDTH: read data.
- `dout_ready` input 1: read accepted when `dout_valid & dout_ready`.
- `afull_thresh` input ADDR_WIDTH+1: almost-full level.
- `aempty_thresh` input ADDR_WIDTH+1: almost-empty level.
- `item_count` output ADDR_WIDTH+1: committed, unread words.
- `used_count` output ADDR_WIDTH+1: committed plus uncommitted words.
- `almost_full` output 1: `used_count >= afull_thresh`.
- `almost_empty` output 1: `item_count <= aempty_thresh`.
- `drop_pulse` output 1: one-cycle pulse on a drop that discarded at least one word.

## Operation
- Pointers are ADDR_WIDTH+1 bits, with the MSB used as the wrap bit: `wptr_spec` (write), `wptr_cmt` (commit boundary) and `rptr` (read). The memory is indexed with the low ADDR_WIDTH bits.
- Enqueue (`enq`) writes `mem[wptr_spec]` and increments `wptr_spec`.
- Commit:
  - `din_commit` with `enq` sets `wptr_cmt <= wptr_spec + 1`.
  - `din_commit` without `enq` sets `wptr_cmt <= wptr_spec`.
- Drop:
  - `din_drop` sets `wptr_spec <= wptr_cmt`.
  - `din_ready` is forced low in any cycle where `din_drop` is high, so no enqueue occurs.
  - When `din_commit` and `din_drop` are both high, drop wins and the commit is ignored.
  - `drop_pulse` = registered (`din_drop & (wptr_spec != wptr_cmt)`).
- Dequeue (`deq`) increments `rptr`. Reads see only committed data (`rptr != wptr_cmt`).
- Counts:
  - `used_count = wptr_spec - rptr`.
  - `item_count = wptr_cmt - rptr`, plus 1 if the output register is full (see Configuration).
  - All arithmetic is modulo 2^(ADDR_WIDTH+1).
- Full/empty:
  - `full = (used_count == D)`.
  - `din_ready = ~full & ~din_drop & ~rst & ~clear`.
- A group larger than D can never commit. The writer must drop it once `din_ready` stalls with `used_count == D` and `item_count == 0`. The FIFO does not detect this deadlock.
- Simultaneous enq and deq are both performed; `used_count` is unchanged.
- `rst`/`clear`: all pointers go to 0, uncommitted and committed data are discarded, and the output register is invalidated.
- Reset values: `din_ready`=0 during reset and 1 on the cycle after; `dout_valid`=0, `item_count`=0, `used_count`=0, `almost_full`=(`afull_thresh`==0), `almost_empty`=1, `drop_pulse`=0. `dout` is undefined when `dout_valid`=0.

## Timing
- All pointer and count registers update on `posedge clk`.
- Watermark compares and `din_ready` are combinational from registers and thresholds.
- Commit-to-valid: a word committed in cycle N gives `dout_valid`=1 in cycle N+1, or N+2 with the output register.
- Drop frees space immediately: `din_ready` can go high in cycle N+1.
- Full throughput is one word per cycle in each direction.
- `dout_valid` is never dependent on `dout_ready` in the same cycle.

## Configuration
- `SIMPLE_COMMIT_FIFO_OUT_REG_EN` defined:
  - Adds a one-entry output register (skid-free, refilled on the same cycle as `deq`).
  - `dout` is driven from a flop.
  - `item_count` includes the register entry.
  - Adds one cycle of commit-to-valid latency.
  - Sustains 1 word/cycle.
- Undefined: `dout = mem[rptr[ADDR_WIDTH-1:0]]` (combinational read) and `dout_valid = (rptr != wptr_cmt)`.

## Test plan
- Write 4 words with `din_commit` on the 4th, `dout_ready`=1 → nothing is valid before commit; words then emerge in order 1 cycle after commit (2 with the macro); `item_count` goes 0→4→0.
- Write 3 words, then assert `din_drop` → `used_count` 3→0, `drop_pulse` for 1 cycle, `dout_valid` stays 0; the next committed group reads out correctly from the reused slots.
- ADDR_WIDTH=3: commit 8 words with no reads → `din_ready`=0 and `used_count`=8; one read → `din_ready`=1 next cycle.
- Assert `din_commit` and `din_drop` in the same cycle with 2 pending words → drop wins, `item_count` unchanged, no enqueue accepted that cycle.
- Apply `clear` mid-stream with 2 committed and 3 pending words → all counts 0 the next cycle and `dout_valid`=0; traffic written after the clear reads out correctly.
- `afull_thresh`=6, `aempty_thresh`=1, ADDR_WIDTH=3: step occupancy 0..8..0 → `almost_full` is high exactly while `used_count`≥6, and `almost_empty` exactly while `item_count`≤1; pointers wrap at least twice without error.
